uart_tx: RTL and testbench

//  UART transmit stage. Sits directly downstream of the system controller.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_tx_if.sv | 34 +++
 rtl/uart_parity_calc.sv | 15 +
 rtl/uart_tx.sv | 133 +++++++++++++
 tb/tb_uart_tx.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states, parity selectors and line levels.
// Imported by the TX datapath and reusable by the RX side.
package uart_pkg;

    localparam int DEF_DATA_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage : uart_pkg

// File: rtl/uart_tx_if.sv
// Byte-offer bus between the system controller (master) and the UART transmitter (slave),
// including the serial line and the Busy back-pressure signal.
interface uart_tx_if
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

    logic [DATA_WIDTH-1:0] p_data;
    logic                  data_valid;
    logic                  par_en;
    logic                  par_typ;
    logic                  tx_out;
    logic                  busy;

    modport master (
        output p_data,
        output data_valid,
        output par_en,
        output par_typ,
        input  tx_out,
        input  busy
    );

    modport slave (
        input  p_data,
        input  data_valid,
        input  par_en,
        input  par_typ,
        output tx_out,
        output busy
    );

endinterface : uart_tx_if

// File: rtl/uart_parity_calc.sv
// Combinational parity generator for a UART payload; even or odd selected by i_par_typ.
// Shared between the transmitter and the receiver's parity checker.
module uart_parity_calc
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_par_typ,
    output logic                  o_parity
);

    assign o_parity = (i_par_typ == PAR_ODD) ? ~^i_data : ^i_data;

endmodule : uart_parity_calc

// File: rtl/uart_tx.sv
// UART transmitter: serialises one byte per frame as start, LSB-first data, optional parity, stop.
// One serial bit per i_clk cycle; TX line and Busy come straight from registers.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic     i_clk,
    input  logic     i_rst_n,
    uart_tx_if.slave bus
);

    localparam int                CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    tx_state_t             r_state;
    tx_state_t             w_next_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] w_next_shift;
    logic [DATA_WIDTH-1:0] w_shift_rot;
    logic [CNT_W-1:0]      r_count;
    logic [CNT_W-1:0]      w_next_count;
    logic                  r_par_en;
    logic                  w_next_par_en;
    logic                  r_par_typ;
    logic                  w_next_par_typ;
    logic                  r_tx;
    logic                  w_next_tx;
    logic                  r_busy;
    logic                  w_next_busy;
    logic                  w_parity;
    logic                  w_accept;

    // The shift register rotates rather than shifts, so after DATA_WIDTH bits it holds the
    // latched byte again and the parity generator sees the original payload.
    assign w_shift_rot = {r_shift[0], r_shift[DATA_WIDTH-1:1]};
    assign w_accept    = bus.data_valid && ((r_state == IDLE) || (r_state == STOP));

    uart_parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity_calc (
        .i_data    (r_shift),
        .i_par_typ (r_par_typ),
        .o_parity  (w_parity)
    );

    always_comb begin
        w_next_state   = r_state;
        w_next_shift   = r_shift;
        w_next_count   = r_count;
        w_next_par_en  = r_par_en;
        w_next_par_typ = r_par_typ;
        w_next_tx      = r_tx;
        w_next_busy    = r_busy;

        case (r_state)
            IDLE: begin
                w_next_tx   = STOP_BIT;
                w_next_busy = 1'b0;
            end
            START: begin
                w_next_state = DATA;
                w_next_tx    = r_shift[0];
                w_next_shift = w_shift_rot;
                w_next_count = '0;
            end
            DATA: begin
                if (r_count == LAST_BIT) begin
                    if (r_par_en) begin
                        w_next_state = PARITY;
                        w_next_tx    = w_parity;
                    end else begin
                        w_next_state = STOP;
                        w_next_tx    = STOP_BIT;
                    end
                end else begin
                    w_next_tx    = r_shift[0];
                    w_next_shift = w_shift_rot;
                    w_next_count = r_count + CNT_W'(1);
                end
            end
            PARITY: begin
                w_next_state = STOP;
                w_next_tx    = STOP_BIT;
            end
            STOP: begin
                w_next_state = IDLE;
                w_next_tx    = STOP_BIT;
                w_next_busy  = 1'b0;
            end
            default: begin
                w_next_state = IDLE;
                w_next_tx    = STOP_BIT;
                w_next_busy  = 1'b0;
            end
        endcase

        // A new byte is only taken from IDLE or the stop cycle; this overrides the above.
        if (w_accept) begin
            w_next_state   = START;
            w_next_shift   = bus.p_data;
            w_next_count   = '0;
            w_next_par_en  = bus.par_en;
            w_next_par_typ = bus.par_typ;
            w_next_tx      = START_BIT;
            w_next_busy    = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_count   <= '0;
            r_par_en  <= 1'b0;
            r_par_typ <= PAR_EVEN;
            r_tx      <= STOP_BIT;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_shift   <= w_next_shift;
            r_count   <= w_next_count;
            r_par_en  <= w_next_par_en;
            r_par_typ <= w_next_par_typ;
            r_tx      <= w_next_tx;
            r_busy    <= w_next_busy;
        end
    end

    assign bus.tx_out = r_tx;
    assign bus.busy   = r_busy;

endmodule : uart_tx

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: fixed frames, rejection, back-to-back, mid-frame reset
// and randomized frames compared against a bit-list frame model.
module tb_uart_tx;

    typedef logic bitQ_t[$];

    logic clk;
    logic rstN;
    int   checks;
    int   failures;

    uart_tx_if #(.DATA_WIDTH(8)) bus ();

    uart_tx #(
        .DATA_WIDTH (8)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rstN),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached, actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // Expected line levels of one frame: start, data LSB first, optional parity, stop.
    function automatic bitQ_t frameModel(input logic [7:0] d, input logic pe, input logic pt);
        bitQ_t q;
        int    ones;
        q = {};
        ones = $countones(d);
        q.push_back(1'b0);
        for (int b = 0; b < 8; b++) q.push_back(d[b]);
        if (pe) begin
            if (pt) q.push_back(((ones % 2) == 0) ? 1'b1 : 1'b0);
            else    q.push_back(((ones % 2) == 1) ? 1'b1 : 1'b0);
        end
        q.push_back(1'b1);
        return q;
    endfunction

    task automatic offer(input logic [7:0] d, input logic pe, input logic pt);
        bus.p_data     = d;
        bus.par_en     = pe;
        bus.par_typ    = pt;
        bus.data_valid = 1'b1;
    endtask

    task automatic test_reset();
        rstN           = 1'b0;
        bus.data_valid = 1'b0;
        bus.p_data     = 8'h00;
        bus.par_en     = 1'b0;
        bus.par_typ    = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (bus.tx_out !== 1'b1 || bus.busy !== 1'b0) begin
                failures++;
                $display("[TB] FAIL reset_hold: tx=%b busy=%b required tx=1 busy=0", bus.tx_out, bus.busy);
            end
        end
        @(negedge clk);
        rstN = 1'b1;
        repeat (6) begin
            @(negedge clk);
            checks++;
            if (bus.tx_out !== 1'b1 || bus.busy !== 1'b0) begin
                failures++;
                $display("[TB] FAIL reset_idle: tx=%b busy=%b required tx=1 busy=0", bus.tx_out, bus.busy);
            end
        end
    endtask

    task automatic test_single_frame(input string name, input logic [7:0] d, input logic pe,
                                     input logic pt, input int frameLen);
        bitQ_t exp;
        int    busyCount;
        exp = frameModel(d, pe, pt);
        busyCount = 0;
        @(negedge clk);
        offer(d, pe, pt);
        for (int i = 0; i < exp.size(); i++) begin
            @(negedge clk);
            bus.data_valid = 1'b0;
            bus.p_data     = 8'($urandom);
            bus.par_en     = 1'($urandom);
            bus.par_typ    = 1'($urandom);
            if (bus.busy === 1'b1) busyCount++;
            checks++;
            if (bus.tx_out !== exp[i]) begin
                failures++;
                $display("[TB] FAIL %s_bit%0d: tx=%b required %b", name, i, bus.tx_out, exp[i]);
            end
        end
        repeat (2) begin
            @(negedge clk);
            if (bus.busy === 1'b1) busyCount++;
            checks++;
            if (bus.tx_out !== 1'b1) begin
                failures++;
                $display("[TB] FAIL %s_idle: tx=%b required 1", name, bus.tx_out);
            end
        end
        checks++;
        if (busyCount != frameLen) begin
            failures++;
            $display("[TB] FAIL %s_busy_len: busy cycles=%0d required %0d", name, busyCount, frameLen);
        end
    endtask

    task automatic test_busy_back_to_back();
        bitQ_t exp1;
        bitQ_t exp2;
        exp1 = frameModel(8'hC6, 1'b1, 1'b0);
        exp2 = frameModel(8'h3C, 1'b0, 1'b0);
        @(negedge clk);
        offer(8'hC6, 1'b1, 1'b0);
        for (int i = 0; i < exp1.size(); i++) begin
            @(negedge clk);
            bus.data_valid = 1'b0;
            bus.p_data     = 8'($urandom);
            checks++;
            if (bus.tx_out !== exp1[i] || bus.busy !== 1'b1) begin
                failures++;
                $display("[TB] FAIL b2b_first_bit%0d: tx=%b busy=%b required tx=%b busy=1",
                         i, bus.tx_out, bus.busy, exp1[i]);
            end
            if (i == 3) offer(8'h55, 1'b0, 1'b0);
            if (i == exp1.size() - 1) offer(8'h3C, 1'b0, 1'b0);
        end
        for (int i = 0; i < exp2.size(); i++) begin
            @(negedge clk);
            bus.data_valid = 1'b0;
            bus.p_data     = 8'($urandom);
            checks++;
            if (bus.tx_out !== exp2[i] || bus.busy !== 1'b1) begin
                failures++;
                $display("[TB] FAIL b2b_second_bit%0d: tx=%b busy=%b required tx=%b busy=1",
                         i, bus.tx_out, bus.busy, exp2[i]);
            end
        end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (bus.tx_out !== 1'b1 || bus.busy !== 1'b0) begin
                failures++;
                $display("[TB] FAIL b2b_idle: tx=%b busy=%b required tx=1 busy=0", bus.tx_out, bus.busy);
            end
        end
    endtask

    task automatic test_mid_reset();
        bitQ_t exp;
        exp = frameModel(8'hFF, 1'b0, 1'b0);
        @(negedge clk);
        offer(8'hFF, 1'b0, 1'b0);
        for (int i = 0; i <= 5; i++) begin
            @(negedge clk);
            bus.data_valid = 1'b0;
            checks++;
            if (bus.tx_out !== exp[i] || bus.busy !== 1'b1) begin
                failures++;
                $display("[TB] FAIL midrst_pre_bit%0d: tx=%b busy=%b required tx=%b busy=1",
                         i, bus.tx_out, bus.busy, exp[i]);
            end
        end
        #2 rstN = 1'b0;
        #1;
        checks++;
        if (bus.tx_out !== 1'b1 || bus.busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midrst_immediate: tx=%b busy=%b required tx=1 busy=0", bus.tx_out, bus.busy);
        end
        @(negedge clk);
        rstN = 1'b1;
        repeat (12) begin
            @(negedge clk);
            checks++;
            if (bus.tx_out !== 1'b1 || bus.busy !== 1'b0) begin
                failures++;
                $display("[TB] FAIL midrst_no_resume: tx=%b busy=%b required tx=1 busy=0", bus.tx_out, bus.busy);
            end
        end
        test_single_frame("midrst_new", 8'h0F, 1'b0, 1'b0, 10);
    endtask

    task automatic test_random();
        localparam int N = 40;
        logic [7:0] dArr  [N];
        logic       peArr [N];
        logic       ptArr [N];
        int         gapArr[N];
        bitQ_t      exp;
        for (int k = 0; k < N; k++) begin
            dArr[k]   = 8'($urandom);
            peArr[k]  = 1'($urandom);
            ptArr[k]  = 1'($urandom);
            gapArr[k] = (($urandom % 3) == 0) ? 0 : int'($urandom_range(1, 3));
        end
        @(negedge clk);
        offer(dArr[0], peArr[0], ptArr[0]);
        for (int k = 0; k < N; k++) begin
            exp = frameModel(dArr[k], peArr[k], ptArr[k]);
            for (int i = 0; i < exp.size(); i++) begin
                @(negedge clk);
                bus.data_valid = 1'b0;
                checks++;
                if (bus.tx_out !== exp[i] || bus.busy !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL rand_f%0d_bit%0d: tx=%b busy=%b required tx=%b busy=1 (data=%h pe=%b pt=%b)",
                             k, i, bus.tx_out, bus.busy, exp[i], dArr[k], peArr[k], ptArr[k]);
                end
                bus.p_data  = 8'($urandom);
                bus.par_en  = 1'($urandom);
                bus.par_typ = 1'($urandom);
                if (i < exp.size() - 1 && ($urandom % 4) == 0) bus.data_valid = 1'b1;
                if (i == exp.size() - 1 && k < N - 1 && gapArr[k] == 0)
                    offer(dArr[k+1], peArr[k+1], ptArr[k+1]);
            end
            if (gapArr[k] != 0 || k == N - 1) begin
                for (int g = 0; g < ((gapArr[k] == 0) ? 1 : gapArr[k]); g++) begin
                    @(negedge clk);
                    bus.data_valid = 1'b0;
                    checks++;
                    if (bus.tx_out !== 1'b1 || bus.busy !== 1'b0) begin
                        failures++;
                        $display("[TB] FAIL rand_gap%0d: tx=%b busy=%b required tx=1 busy=0",
                                 k, bus.tx_out, bus.busy);
                    end
                end
                if (k < N - 1) offer(dArr[k+1], peArr[k+1], ptArr[k+1]);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        $display("[TB] uart_tx bench starting");
        test_reset();
        test_single_frame("nopar_A5", 8'hA5, 1'b0, 1'b0, 10);
        test_single_frame("even_03", 8'h03, 1'b1, 1'b0, 11);
        test_single_frame("odd_03", 8'h03, 1'b1, 1'b1, 11);
        test_busy_back_to_back();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_uart_tx
